mux21_arbiter: RTL and testbench



---
 rtl/mux21_arbiter_pkg.sv | 28 ++
 rtl/mux21_arbiter_if.sv | 17 +
 rtl/Mux21.sv | 10 +
 rtl/mux21_arbiter_burst_counter.sv | 24 ++
 rtl/mux21_arbiter.sv | 100 ++++++++++
 tb/tb_mux21_arbiter.sv | 210 +++++++++++++++++++++
 6 files changed

// File: rtl/mux21_arbiter_pkg.sv
// Shared types and constants for the two-requester mux select arbiter.
package mux21_arb_pkg;

    // Arbiter states: nobody owns the mux, or requester 0/1 owns it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } arbState_t;

    // One-hot grant encodings returned to the requesters.
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_0    = 2'b01;
    localparam logic [1:0] GNT_1    = 2'b10;

    // Default burst counter width; must hold MAX_BURST-1 with room to saturate.
    localparam int DEFAULT_CNT_W = 8;

    // Grant vector implied by a state; a state can never map to 2'b11.
    function automatic logic [1:0] stateToGnt(arbState_t s);
        case (s)
            G0:      return GNT_0;
            G1:      return GNT_1;
            default: return GNT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mux21_arbiter_if.sv
// Request/grant bundle between the arbiter and its two requesters.
interface mux21_arbiter_if
    import mux21_arb_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
);
    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             sel;
    logic             busy;
    logic [CNT_W-1:0] burst_cnt;

    // Arbiter side: consumes requests, drives grant, select and status.
    modport master (input req, output gnt, sel, busy, burst_cnt);
    // Requester side: drives requests, observes grant, select and status.
    modport slave  (output req, input gnt, sel, busy, burst_cnt);
endinterface

// File: rtl/Mux21.sv
// Shared 2:1 single-bit mux whose select is owned by mux21_arbiter.
module Mux21 (
    input  logic [1:0] in,
    input  logic       sel,
    output logic       out
);

    assign out = in[sel];

endmodule

// File: rtl/mux21_arbiter_burst_counter.sv
// Saturating up-counter with synchronous clear and enable; counts how long
// the current owner has held a shared resource.
module burst_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    // Clear wins over enable; counting stops at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        // NOTE: registers are written with <= so every flop samples its inputs
        // from the same edge, independent of statement order.
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mux21_arbiter.sv
// Round-robin arbiter for two level requesters sharing Mux21. Issues a
// registered one-hot grant, drives the mux select, and forces a handover
// after MAX_BURST contended cycles so neither side starves.
module mux21_arbiter
    import mux21_arb_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    mux21_arbiter_if.master        bus
);

    arbState_t        state;
    arbState_t        nextState;
    logic             lastOwner;
    logic             selReg;
    logic             stayGrant;
    logic             atLimit;
    logic [CNT_W-1:0] burstCnt;

    // Burst length: cleared on every grant entry and in idle, advanced while
    // the current owner keeps the grant.
    burst_counter #(
        .CNT_W (CNT_W)
    ) u_burst_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (!stayGrant),
        .enable (stayGrant),
        .count  (burstCnt)
    );

    // Next-state arbitration: release, contention limit and round-robin tie break.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        nextState = state;
        stayGrant = 1'b0;
        // A saturated uncontended burst is already past the limit, so the
        // comparison is >= rather than ==.
        atLimit   = (burstCnt >= CNT_W'(MAX_BURST - 1));

        case (state)
            IDLE: begin
                if (bus.req == 2'b11) begin
                    nextState = lastOwner ? G0 : G1;
                end else if (bus.req[0]) begin
                    nextState = G0;
                end else if (bus.req[1]) begin
                    nextState = G1;
                end
            end
            G0: begin
                if (!bus.req[0]) begin
                    nextState = bus.req[1] ? G1 : IDLE;
                end else if (bus.req[1] && atLimit) begin
                    nextState = G1;
                end else begin
                    stayGrant = 1'b1;
                end
            end
            G1: begin
                if (!bus.req[1]) begin
                    nextState = bus.req[0] ? G0 : IDLE;
                end else if (bus.req[0] && atLimit) begin
                    nextState = G0;
                end else begin
                    stayGrant = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // State, priority pointer and select registers; the select holds in idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lastOwner <= 1'b1;
            selReg    <= 1'b0;
        end else begin
            state <= nextState;
            if (nextState == G0) begin
                lastOwner <= 1'b0;
                selReg    <= 1'b0;
            end else if (nextState == G1) begin
                lastOwner <= 1'b1;
                selReg    <= 1'b1;
            end
        end
    end

    assign bus.gnt       = stateToGnt(state);
    assign bus.sel       = selReg;
    assign bus.busy      = (state != IDLE);
    assign bus.burst_cnt = burstCnt;

endmodule

// File: tb/tb_mux21_arbiter.sv
// Self-checking bench for mux21_arbiter driving a real Mux21. Expected values
// come from a cycle-level model of the ownership rules kept in plain integers.
module tb_mux21_arbiter;

    localparam int MAX_BURST = 4;
    localparam int CNT_W     = 8;
    localparam int CNT_SAT   = (1 << CNT_W) - 1;

    logic       clk;
    logic       rst;
    logic [1:0] muxIn;
    logic       muxOut;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: owner -1 = idle, else index of the granted requester.
    int mOwner;
    int mCnt;
    int mLast;
    int mSel;

    // Contended-run watch on the DUT grant.
    int runHolder = -1;
    int runLen    = 0;

    mux21_arbiter_if #(.CNT_W(CNT_W)) bus ();

    mux21_arbiter #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    Mux21 u_mux (
        .in  (muxIn),
        .sel (bus.sel),
        .out (muxOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hand ownership to requester i and restart its burst.
    task automatic modelEnter(input int i);
        mOwner = i;
        mLast  = i;
        mSel   = i;
        mCnt   = 0;
    endtask

    // Apply one clock edge of the arbitration rules to the model.
    task automatic modelEdge(input logic [1:0] r, input logic rs);
        int o;
        if (rs) begin
            mOwner = -1;
            mCnt   = 0;
            mLast  = 1;
            mSel   = 0;
        end else if (mOwner < 0) begin
            if (r == 2'b11)   modelEnter(1 - mLast);
            else if (r[0])    modelEnter(0);
            else if (r[1])    modelEnter(1);
        end else begin
            o = mOwner;
            if (!r[o]) begin
                if (r[1-o]) modelEnter(1 - o);
                else begin
                    mOwner = -1;
                    mCnt   = 0;
                end
            end else if (r[1-o] && (mCnt + 1 >= MAX_BURST)) begin
                modelEnter(1 - o);
            end else begin
                mCnt = (mCnt < CNT_SAT) ? mCnt + 1 : CNT_SAT;
            end
        end
    endtask

    // One clock: watch contended run length, advance model, compare outputs.
    task automatic step();
        int h;
        logic [1:0] g;
        g = bus.gnt;
        h = (g == 2'b01) ? 0 : (g == 2'b10) ? 1 : -1;
        if (h >= 0 && !rst && bus.req[1-h]) runLen = (h == runHolder) ? runLen + 1 : 1;
        else runLen = 0;
        runHolder = h;
        check("burst_len_ok", 32'(runLen <= MAX_BURST), 32'd1);

        @(posedge clk);
        modelEdge(bus.req, rst);
        #1;
        check("gnt", 32'(bus.gnt), (mOwner < 0) ? 32'd0 : 32'(1 << mOwner));
        check("sel", 32'(bus.sel), 32'(mSel));
        check("busy", 32'(bus.busy), 32'(mOwner >= 0));
        check("burst_cnt", 32'(bus.burst_cnt), 32'(mCnt));
        check("mux_out", 32'(muxOut), 32'(muxIn[mSel]));
        check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
        if (bus.busy) check("sel_vs_gnt", 32'(bus.sel), 32'(bus.gnt[1]));
    endtask

    task automatic doReset();
        rst     = 1'b1;
        bus.req = 2'b00;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] expGnt;
        rst     = 1'b1;
        bus.req = 2'b00;
        muxIn   = 2'b01;
        mOwner  = -1;
        mCnt    = 0;
        mLast   = 1;
        mSel    = 0;

        // Reset values.
        doReset();
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_sel", 32'(bus.sel), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_cnt", 32'(bus.burst_cnt), 32'd0);

        // Single request: one-cycle latency, mux passes in[0].
        bus.req = 2'b01;
        step();
        check("first_gnt", 32'(bus.gnt), 32'h1);
        check("first_sel", 32'(bus.sel), 32'd0);
        check("first_mux", 32'(muxOut), 32'd1);

        // Contention from idle: 4 cycles to 0, 4 to 1, then back to 0.
        doReset();
        muxIn   = 2'b10;
        bus.req = 2'b11;
        for (int c = 0; c < 9; c++) begin
            step();
            expGnt = (c < 4 || c == 8) ? 2'b01 : 2'b10;
            check("rr_gnt", 32'(bus.gnt), 32'(expGnt));
            check("rr_sel", 32'(bus.sel), 32'(expGnt[1]));
        end

        // Long uncontended burst saturates, then contention hands over at once.
        doReset();
        bus.req = 2'b10;
        for (int c = 0; c < 300; c++) step();
        check("sat_gnt", 32'(bus.gnt), 32'h2);
        check("sat_cnt", 32'(bus.burst_cnt), 32'(CNT_SAT));
        bus.req = 2'b11;
        step();
        check("sat_handover", 32'(bus.gnt), 32'h1);
        check("sat_handover_cnt", 32'(bus.burst_cnt), 32'd0);

        // Owner 0 releases early while 1 is waiting: direct one-hot switch.
        doReset();
        bus.req = 2'b01;
        step();
        bus.req = 2'b11;
        step();
        check("rel_cnt_before", 32'(bus.burst_cnt), 32'd1);
        bus.req = 2'b10;
        step();
        check("rel_gnt", 32'(bus.gnt), 32'h2);
        check("rel_cnt", 32'(bus.burst_cnt), 32'd0);

        // Reset mid-burst, then re-arbitrate from the reset pointer.
        doReset();
        bus.req = 2'b10;
        step();
        step();
        step();
        check("mid_cnt", 32'(bus.burst_cnt), 32'd2);
        rst     = 1'b1;
        bus.req = 2'b11;
        step();
        check("mid_rst_gnt", 32'(bus.gnt), 32'd0);
        check("mid_rst_cnt", 32'(bus.burst_cnt), 32'd0);
        check("mid_rst_sel", 32'(bus.sel), 32'd0);
        rst = 1'b0;
        step();
        check("mid_rearb_gnt", 32'(bus.gnt), 32'h1);

        // Random traffic with occasional resets.
        for (int c = 0; c < 10000; c++) begin
            bus.req = 2'($urandom_range(0, 3));
            muxIn   = 2'($urandom_range(0, 3));
            rst     = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
